// File: rtl/ahb_simple_master.sv
// Single-master AHB-Lite bridge: turns a req/gnt/resp port into pipelined SINGLE transfers,
// with in-order responses and a saturating count of ERROR responses.
module ahb_simple_master #(
    parameter int unsigned err_cnt_w = 8
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 req,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [2:0]           req_size,
    output logic                 req_gnt,
    output logic                 resp_vld,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    input  logic                 err_cnt_clr,
    output logic [err_cnt_w-1:0] err_cnt,
    output logic [31:0]          haddr,
    output logic [31:0]          hwdata,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [2:0]           hsize,
    output logic [2:0]           hburst,
    input  logic [31:0]          hrdata,
    input  logic [1:0]           hresp,
    input  logic                 hready
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_NONSEQ = 2'b10
    } htrans_e;

    // Address-phase slot A
    logic                 a_vld_q, a_vld_d;
    logic [31:0]          a_addr_q, a_addr_d;
    logic                 a_we_q, a_we_d;
    logic [2:0]           a_size_q, a_size_d;
    logic [31:0]          a_wdata_q, a_wdata_d;
    // Data-phase slot D
    logic                 d_vld_q, d_vld_d;
    logic                 d_we_q, d_we_d;
    logic [31:0]          d_wdata_q, d_wdata_d;
    // Response and error counter
    logic                 resp_vld_q, resp_vld_d;
    logic                 resp_err_q, resp_err_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic [err_cnt_w-1:0] err_cnt_q, err_cnt_d;

    logic                 err1_s;
    logic                 gnt_s;
    logic                 done_s;
    logic                 resp_bad_s;

    // Bus handshake decode: first ERROR cycle, grant and data-phase completion
    always_comb begin
        resp_bad_s = (hresp != 2'b00);
        err1_s     = d_vld_q & resp_bad_s & ~hready;
        gnt_s      = req & (~a_vld_q | hready) & ~err1_s;
        done_s     = d_vld_q & hready;
    end

    // Pipeline slot next-state: D takes A on hready, A takes a granted request
    always_comb begin
        a_vld_d   = a_vld_q;
        a_addr_d  = a_addr_q;
        a_we_d    = a_we_q;
        a_size_d  = a_size_q;
        a_wdata_d = a_wdata_q;
        d_vld_d   = d_vld_q;
        d_we_d    = d_we_q;
        d_wdata_d = d_wdata_q;
        if (hready) begin
            d_vld_d   = a_vld_q;
            d_we_d    = a_we_q;
            d_wdata_d = a_wdata_q;
            a_vld_d   = 1'b0;
        end else begin
            a_vld_d   = a_vld_q;
        end
        if (gnt_s) begin
            a_vld_d   = 1'b1;
            a_addr_d  = req_addr;
            a_we_d    = req_we;
            a_size_d  = req_size;
            a_wdata_d = req_wdata;
        end else begin
            a_addr_d  = a_addr_q;
        end
    end

    // Response capture and saturating error count; clear beats increment
    always_comb begin
        resp_vld_d   = done_s;
        resp_err_d   = done_s & resp_bad_s;
        resp_rdata_d = 32'h0000_0000;
        err_cnt_d    = err_cnt_q;
        if (done_s && !d_we_q && !resp_bad_s) begin
            resp_rdata_d = hrdata;
        end else begin
            resp_rdata_d = 32'h0000_0000;
        end
        if (err_cnt_clr) begin
            err_cnt_d = {err_cnt_w{1'b0}};
        end else if (done_s && resp_bad_s && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + err_cnt_w'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            a_vld_q      <= 1'b0;
            a_addr_q     <= 32'h0000_0000;
            a_we_q       <= 1'b0;
            a_size_q     <= 3'b000;
            a_wdata_q    <= 32'h0000_0000;
            d_vld_q      <= 1'b0;
            d_we_q       <= 1'b0;
            d_wdata_q    <= 32'h0000_0000;
            resp_vld_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            err_cnt_q    <= {err_cnt_w{1'b0}};
        end else begin
            a_vld_q      <= a_vld_d;
            a_addr_q     <= a_addr_d;
            a_we_q       <= a_we_d;
            a_size_q     <= a_size_d;
            a_wdata_q    <= a_wdata_d;
            d_vld_q      <= d_vld_d;
            d_we_q       <= d_we_d;
            d_wdata_q    <= d_wdata_d;
            resp_vld_q   <= resp_vld_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Address is hidden during the first ERROR cycle and re-presented in the second
    always_comb begin
        htrans     = (a_vld_q && !err1_s) ? TRANS_NONSEQ : TRANS_IDLE;
        haddr      = a_addr_q;
        hwrite     = a_we_q;
        hsize      = a_size_q;
        hwdata     = d_wdata_q;
        hburst     = 3'b000;
        req_gnt    = gnt_s;
        resp_vld   = resp_vld_q;
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
        err_cnt    = err_cnt_q;
    end

endmodule
